// File: rtl/linebuf_ctrl_pkg.sv
// Shared definitions for the scanline sequencer: FSM encoding and pixel field layout.
package linebuf_ctrl_pkg;

    // Encoding is exported on the phase output, so values are pinned.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StClear  = 3'd1,
        StTile   = 3'd2,
        StSprRd  = 3'd3,
        StSprChk = 3'd4,
        StDone   = 3'd5
    } state_e;

    // Pixel layout: [3:0] colour, [5:4] palette, [6] sprite marker, [7] tile priority.
    localparam int unsigned ColLsb    = 0;
    localparam int unsigned ColMsb    = 3;
    localparam int unsigned PalLsb    = 4;
    localparam int unsigned PalMsb    = 5;
    localparam int unsigned MarkerBit = 6;
    localparam int unsigned PrioBit   = 7;

    // Colour 0 is transparent.
    function automatic logic px_opaque(input logic [7:0] px);
        return px[ColMsb:ColLsb] != 4'h0;
    endfunction

endpackage

// File: rtl/linebuf_merge.sv
// Sprite-over-line merge decision: decides whether a sprite pixel lands on the old pixel.
module linebuf_merge
    import linebuf_ctrl_pkg::*;
(
    input  logic [7:0] old_px,
    input  logic [7:0] new_px,
    input  logic       prio,
    output logic       wren,
    output logic [7:0] wrdata
);

    logic old_marked;
    logic old_tile_prio;
    logic unused_bits;

    assign old_marked    = old_px[MarkerBit];
    assign old_tile_prio = old_px[PrioBit];

    // Palette of the old pixel and the incoming marker bit play no part in the decision.
    assign unused_bits = ^{old_px[PalMsb:PalLsb], new_px[MarkerBit]};

    // Opaque sprite wins unless an earlier sprite already owns the pixel, or an opaque
    // tile pixel claims priority over a low-priority sprite.
    always_comb begin
        wren   = px_opaque(new_px) && !old_marked &&
                 (prio || !old_tile_prio || !px_opaque(old_px));
        wrdata = new_px;
        wrdata[MarkerBit] = 1'b1;
    end

endmodule

// File: rtl/linebuf_ctrl.sv
// Scanline sequencer for the double-buffered line buffer: flip, clear, tile pass, sprite pass.
module linebuf_ctrl
    import linebuf_ctrl_pkg::*;
#(
    parameter int unsigned CLEAR_LEN = 320,
    parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       line_start,
    input  logic       render_en,
    output logic       linesel,
    output logic [8:0] lb_idx,
    output logic [7:0] lb_wrdata,
    output logic       lb_wren,
    input  logic [7:0] lb_rddata,
    input  logic       tile_req,
    input  logic [8:0] tile_idx,
    input  logic [7:0] tile_data,
    output logic       tile_ack,
    input  logic       tile_done,
    input  logic       spr_req,
    input  logic [8:0] spr_idx,
    input  logic [7:0] spr_data,
    input  logic       spr_prio,
    output logic       spr_ack,
    input  logic       spr_done,
    output logic [2:0] phase,
    output logic       overrun
);

    localparam logic [8:0] LastIdx = 9'(CLEAR_LEN - 1);

    state_e     state_q;
    logic       linesel_q;
    logic       render_en_q;
    logic [8:0] counter_q;
    logic [8:0] spr_idx_q;
    logic [7:0] spr_data_q;
    logic       spr_prio_q;
    logic       done_pend_q;
    logic       overrun_q;

    logic       merge_wren;
    logic [7:0] merge_wrdata;

    linebuf_merge u_merge (
        .old_px (lb_rddata),
        .new_px (spr_data_q),
        .prio   (spr_prio_q),
        .wren   (merge_wren),
        .wrdata (merge_wrdata)
    );

    // Sequencer FSM; line_start preempts any phase and abandons work in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            linesel_q   <= 1'b0;
            render_en_q <= 1'b0;
            counter_q   <= '0;
            spr_idx_q   <= '0;
            spr_data_q  <= '0;
            spr_prio_q  <= 1'b0;
            done_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (line_start) begin
                linesel_q   <= ~linesel_q;
                render_en_q <= render_en;
                counter_q   <= '0;
                done_pend_q <= 1'b0;
                state_q     <= StClear;
                if (state_q != StIdle && state_q != StDone) begin
                    overrun_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    StClear: begin
                        counter_q <= counter_q + 9'd1;
                        if (counter_q == LastIdx) begin
                            state_q <= render_en_q ? StTile : StDone;
                        end
                    end
                    StTile: begin
                        if (tile_done) begin
                            state_q <= StSprRd;
                        end
                    end
                    StSprRd: begin
                        if (spr_req) begin
                            spr_idx_q   <= spr_idx;
                            spr_data_q  <= spr_data;
                            spr_prio_q  <= spr_prio;
                            // A done arriving with the last pixel waits for its write.
                            done_pend_q <= spr_done;
                            state_q     <= StSprChk;
                        end else if (spr_done) begin
                            state_q <= StDone;
                        end
                    end
                    StSprChk: begin
                        state_q     <= (done_pend_q || spr_done) ? StDone : StSprRd;
                        done_pend_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Render-port mux and handshakes, decoded from the current phase.
    always_comb begin
        lb_idx    = '0;
        lb_wrdata = '0;
        lb_wren   = 1'b0;
        tile_ack  = 1'b0;
        spr_ack   = 1'b0;
        case (state_q)
            StClear: begin
                lb_idx    = counter_q;
                lb_wrdata = CLEAR_VAL;
                lb_wren   = 1'b1;
            end
            StTile: begin
                lb_idx    = tile_idx;
                lb_wrdata = tile_data;
                lb_wren   = tile_req;
                tile_ack  = tile_req;
            end
            StSprRd: begin
                lb_idx  = spr_idx;
                // Not accepted when the line is being restarted under it.
                spr_ack = spr_req && !line_start;
            end
            StSprChk: begin
                lb_idx    = spr_idx_q;
                lb_wrdata = merge_wrdata;
                lb_wren   = merge_wren;
            end
            default: ;
        endcase
    end

    assign linesel = linesel_q;
    assign phase   = state_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Self-checking bench for linebuf_ctrl: write scoreboard plus per-scenario checks.
module tb_linebuf_ctrl;

    localparam logic [2:0] PIdle   = 3'd0;
    localparam logic [2:0] PClear  = 3'd1;
    localparam logic [2:0] PTile   = 3'd2;
    localparam logic [2:0] PSprRd  = 3'd3;
    localparam logic [2:0] PSprChk = 3'd4;
    localparam logic [2:0] PDone   = 3'd5;

    logic       clk;
    logic       reset_n;
    logic       line_start;
    logic       render_en;
    logic       linesel;
    logic [8:0] lb_idx;
    logic [7:0] lb_wrdata;
    logic       lb_wren;
    logic [7:0] lb_rddata;
    logic       tile_req;
    logic [8:0] tile_idx;
    logic [7:0] tile_data;
    logic       tile_ack;
    logic       tile_done;
    logic       spr_req;
    logic [8:0] spr_idx;
    logic [7:0] spr_data;
    logic       spr_prio;
    logic       spr_ack;
    logic       spr_done;
    logic [2:0] phase;
    logic       overrun;

    int total;
    int bad;
    logic        mon_en;
    logic [16:0] sb[$];
    logic [7:0]  mem[0:1023];

    linebuf_ctrl #(
        .CLEAR_LEN (320),
        .CLEAR_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_start (line_start),
        .render_en  (render_en),
        .linesel    (linesel),
        .lb_idx     (lb_idx),
        .lb_wrdata  (lb_wrdata),
        .lb_wren    (lb_wren),
        .lb_rddata  (lb_rddata),
        .tile_req   (tile_req),
        .tile_idx   (tile_idx),
        .tile_data  (tile_data),
        .tile_ack   (tile_ack),
        .tile_done  (tile_done),
        .spr_req    (spr_req),
        .spr_idx    (spr_idx),
        .spr_data   (spr_data),
        .spr_prio   (spr_prio),
        .spr_ack    (spr_ack),
        .spr_done   (spr_done),
        .phase      (phase),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous line buffer, render side selected by linesel.
    always @(posedge clk) begin
        if (lb_wren) mem[{linesel, lb_idx}] <= lb_wrdata;
        lb_rddata <= mem[{linesel, lb_idx}];
    end

    // Every render write must match the oldest expected write.
    always @(negedge clk) begin
        if (mon_en && reset_n && lb_wren) begin
            logic [16:0] exp;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got idx=%0d data=%h want none", lb_idx, lb_wrdata);
            end else begin
                exp = sb.pop_front();
                if ({lb_idx, lb_wrdata} !== exp) begin
                    bad++;
                    $display("FAIL write: got idx=%0d data=%h want idx=%0d data=%h",
                             lb_idx, lb_wrdata, exp[16:8], exp[7:0]);
                end
            end
        end
    end

    task automatic push_clear();
        for (int i = 0; i < 320; i++) sb.push_back({9'(i), 8'h00});
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({linesel, lb_idx, lb_wrdata, lb_wren, tile_ack, spr_ack, overrun} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {linesel, lb_idx, lb_wrdata, lb_wren, tile_ack, spr_ack, overrun});
        end
        total++;
        if (phase !== PIdle) begin
            bad++;
            $display("FAIL reset_phase: got %0d want %0d", phase, PIdle);
        end
        #20 reset_n = 1'b1;
    endtask

    task automatic test_clear_only();
        @(posedge clk); #1;
        line_start = 1'b1; render_en = 1'b0;
        push_clear();
        @(posedge clk); #1;
        line_start = 1'b0;
        tile_req = 1'b1; tile_idx = 9'd7; tile_data = 8'h55;
        total++;
        if (linesel !== 1'b1) begin
            bad++;
            $display("FAIL clear_linesel: got %b want 1", linesel);
        end
        total++;
        if (tile_ack !== 1'b0) begin
            bad++;
            $display("FAIL clear_tile_ack: got %b want 0", tile_ack);
        end
        repeat (319) @(posedge clk);
        #1;
        total++;
        if (phase !== PClear) begin
            bad++;
            $display("FAIL clear_len_320: got %0d want %0d", phase, PClear);
        end
        @(posedge clk); #1;
        total++;
        if (phase !== PDone) begin
            bad++;
            $display("FAIL clear_done_321: got %0d want %0d", phase, PDone);
        end
        total++;
        if ({tile_ack, lb_wren} !== 2'b00) begin
            bad++;
            $display("FAIL done_ignores_tile: got %b want 00", {tile_ack, lb_wren});
        end
        tile_req = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL clear_count: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_tile();
        line_start = 1'b1; render_en = 1'b1;
        push_clear();
        @(posedge clk); #1;
        line_start = 1'b0;
        total++;
        if ({overrun, linesel} !== 2'b00) begin
            bad++;
            $display("FAIL tile_start: got overrun,linesel=%b want 00", {overrun, linesel});
        end
        repeat (320) @(posedge clk);
        #1;
        total++;
        if (phase !== PTile) begin
            bad++;
            $display("FAIL tile_phase: got %0d want %0d", phase, PTile);
        end
        tile_req = 1'b1; tile_idx = 9'd10; tile_data = 8'h83;
        sb.push_back({9'd10, 8'h83});
        #1;
        total++;
        if (tile_ack !== 1'b1) begin
            bad++;
            $display("FAIL tile_ack: got %b want 1", tile_ack);
        end
        @(posedge clk); #1;
        tile_idx = 9'd5; tile_data = 8'h23; tile_done = 1'b1;
        sb.push_back({9'd5, 8'h23});
        #1;
        total++;
        if (tile_ack !== 1'b1) begin
            bad++;
            $display("FAIL tile_ack_with_done: got %b want 1", tile_ack);
        end
        @(posedge clk); #1;
        tile_req = 1'b0; tile_done = 1'b0;
        total++;
        if (phase !== PSprRd) begin
            bad++;
            $display("FAIL tile_to_spr: got %0d want %0d", phase, PSprRd);
        end
    endtask

    task automatic send_sprite(input logic [8:0] idx, input logic [7:0] data, input logic prio,
                               input logic done, input logic wr, input logic [7:0] exp);
        spr_req = 1'b1; spr_idx = idx; spr_data = data; spr_prio = prio; spr_done = done;
        if (wr) sb.push_back({idx, exp});
        #1;
        total++;
        if (spr_ack !== 1'b1) begin
            bad++;
            $display("FAIL spr_ack %h: got %b want 1", data, spr_ack);
        end
        @(posedge clk); #1;
        spr_req = 1'b0; spr_done = 1'b0;
        total++;
        if (phase !== PSprChk) begin
            bad++;
            $display("FAIL spr_chk %h: got %0d want %0d", data, phase, PSprChk);
        end
        @(posedge clk); #1;
        total++;
        if (phase !== (done ? PDone : PSprRd)) begin
            bad++;
            $display("FAIL spr_next %h: got %0d want %0d", data, phase, done ? PDone : PSprRd);
        end
    endtask

    task automatic test_sprite();
        send_sprite(9'd10, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00);
        send_sprite(9'd10, 8'h05, 1'b1, 1'b0, 1'b1, 8'h45);
        send_sprite(9'd10, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00);
        send_sprite(9'd30, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00);
        send_sprite(9'd40, 8'h81, 1'b0, 1'b0, 1'b1, 8'hC1);
        send_sprite(9'd50, 8'h02, 1'b0, 1'b1, 1'b1, 8'h42);
        total++;
        if (mem[{1'b0, 9'd10}] !== 8'h45) begin
            bad++;
            $display("FAIL mem_idx10: got %h want 45", mem[{1'b0, 9'd10}]);
        end
        spr_req = 1'b1;
        #1;
        total++;
        if (spr_ack !== 1'b0) begin
            bad++;
            $display("FAIL spr_outside_phase: got %b want 0", spr_ack);
        end
        spr_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic prev;
        @(posedge clk); #1;
        line_start = 1'b1; render_en = 1'b1;
        push_clear();
        @(posedge clk); #1;
        line_start = 1'b0;
        repeat (320) @(posedge clk);
        #1;
        tile_req = 1'b1; tile_idx = 9'd3; tile_data = 8'h11;
        sb.push_back({9'd3, 8'h11});
        @(posedge clk); #1;
        tile_req = 1'b0;
        line_start = 1'b1; render_en = 1'b0;
        prev = linesel;
        push_clear();
        @(posedge clk); #1;
        line_start = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_pulse: got %b want 1", overrun);
        end
        total++;
        if (linesel !== ~prev) begin
            bad++;
            $display("FAIL overrun_linesel: got %b want %b", linesel, ~prev);
        end
        total++;
        if ({phase, lb_idx, lb_wren} !== {PClear, 9'd0, 1'b1}) begin
            bad++;
            $display("FAIL overrun_restart: got phase=%0d idx=%0d wren=%b want 1/0/1",
                     phase, lb_idx, lb_wren);
        end
        @(posedge clk); #1;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_one_cycle: got %b want 0", overrun);
        end
        repeat (319) @(posedge clk);
        #1;
        total++;
        if (phase !== PDone) begin
            bad++;
            $display("FAIL overrun_clear_done: got %0d want %0d", phase, PDone);
        end
    endtask

    task automatic test_async_reset();
        mon_en = 1'b0;
        line_start = 1'b1; render_en = 1'b0;
        @(posedge clk); #1;
        line_start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        total++;
        if ({linesel, phase, lb_wren} !== {1'b1, PClear, 1'b1}) begin
            bad++;
            $display("FAIL pre_reset: got %b want %b", {linesel, phase, lb_wren},
                     {1'b1, PClear, 1'b1});
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({linesel, lb_idx, lb_wrdata, lb_wren, tile_ack, spr_ack, overrun} !== 21'd0) begin
            bad++;
            $display("FAIL async_reset_outputs: got %h want 0",
                     {linesel, lb_idx, lb_wrdata, lb_wren, tile_ack, spr_ack, overrun});
        end
        total++;
        if (phase !== PIdle) begin
            bad++;
            $display("FAIL async_reset_phase: got %0d want %0d", phase, PIdle);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; mon_en = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        reset_n = 1'b0; line_start = 1'b0; render_en = 1'b0;
        tile_req = 1'b0; tile_idx = '0; tile_data = '0; tile_done = 1'b0;
        spr_req = 1'b0; spr_idx = '0; spr_data = '0; spr_prio = 1'b0; spr_done = 1'b0;
        test_reset();
        test_clear_only();
        test_tile();
        test_sprite();
        test_back_to_back();
        test_async_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/linebuf_ctrl.md
# linebuf_ctrl

Scanline sequencer for the double-buffered video line buffer. At each scanline start it flips the buffer select. It clears the newly owned render line, then grants the render-side port first to the tile renderer and then to the sprite renderer. Sprite pixels are merged by read-modify-write with transparency and priority rules. The display-side port is untouched; only linesel is shared with it.

## Interface
- CLEAR_LEN, 320: number of entries cleared per line (indices 0..CLEAR_LEN-1, max 512)
- CLEAR_VAL, 8'h00: value written during clear
- clk  in  1  video clock
- reset_n  in  1  asynchronous, active-low reset
- line_start  in  1  one-cycle pulse at start of each scanline
- render_en  in  1  sampled at line_start; 0 = clear only, skip tile/sprite phases
- linesel  out  1  buffer select to line buffer (render side owns linesel, display owns !linesel)
- lb_idx  out  9  render-port index
- lb_wrdata  out  8  render-port write data
- lb_wren  out  1  render-port write enable
- lb_rddata  in  8  render-port read data (synchronous RAM, 1-cycle latency)
- tile_req / tile_idx[8:0] / tile_data[7:0]  in  tile pixel write request
- tile_ack  out  1  tile write performed this cycle
- tile_done  in  1  pulse: tile renderer finished line
- spr_req / spr_idx[8:0] / spr_data[7:0] / spr_prio  in  sprite pixel request
- spr_ack  out  1  sprite request accepted this cycle
- spr_done  in  1  pulse: sprite renderer finished line
- phase  out  3  current state encoding
- overrun  out  1  one-cycle pulse: line_start arrived before DONE/IDLE

## Operation
- States: IDLE, CLEAR, TILE, SPR_RD, SPR_CHK, DONE.
- line_start, any state: toggle linesel, latch render_en, counter←0, go CLEAR. If the state was not IDLE/DONE, pulse overrun. Work in progress is abandoned; no pending ack is issued.
- CLEAR: lb_idx=counter, lb_wrdata=CLEAR_VAL, lb_wren=1, counter++. After the write at CLEAR_LEN-1, go TILE if render_en, else DONE.
- TILE: lb_idx/lb_wrdata/lb_wren mirror tile_idx/tile_data/tile_req combinationally; tile_ack=tile_req. tile_done → SPR_RD. A tile_req in the same cycle as tile_done is still written and acked.
- SPR_RD: if spr_req, spr_ack=1, latch idx/data/prio, lb_idx=spr_idx (read), go SPR_CHK. spr_done with no spr_req → DONE; with spr_req → accept the pixel, then DONE after SPR_CHK.
- SPR_CHK: lb_rddata = old pixel. Write latched data with bit6 forced to 1 iff data[3:0]≠0 AND old[6]=0 AND (prio OR old[7]=0 OR old[3:0]=0). Return to SPR_RD.
- Pixel format: [3:0] colour (0 = transparent), [5:4] palette, [6] sprite-written marker, [7] tile-over-sprite priority.
- DONE: lb_wren=0; wait for line_start.
- Requests outside their phase are ignored (no ack).

## Timing
- Reset: state=IDLE, linesel=0, lb_idx=0, lb_wrdata=0, lb_wren=0, tile_ack=0, spr_ack=0, overrun=0, counter=0, phase=IDLE.
- linesel changes on the clock edge following line_start; first clear write occurs in the cycle after that edge.
- Clear takes exactly CLEAR_LEN cycles.
- Tile throughput: 1 pixel/cycle, zero-latency ack.
- Sprite throughput: 1 pixel per 2 cycles. spr_ack comes in SPR_RD; the write comes in the next cycle (SPR_CHK).
- Outputs lb_* are combinational from state/registers; no glitch requirements beyond synchronous use.

## Structure
- Shared package: state encoding constants, pixel field bit positions (colour, palette, marker, priority).
- Sub-module: linebuf_merge, combinational sprite write decision (old pixel, new pixel, prio → wren, wrdata).

## Test plan
- Reset, then line_start with render_en=0 → linesel=1; 320 writes of 00 at idx 0..319; DONE at cycle 321; tile_req ignored.
- render_en=1: tile writes idx 5 ← 8'h23, tile_done → that cycle is acked and written; state SPR_RD.
- Sprite 8'h05 prio=0 over tile 8'h83 → not written. Sprite 8'h05 prio=1 → 8'h45 written. Second sprite 8'h07 at same idx → blocked by marker.
- Sprite colour 0 (8'h30) → no write; over cleared pixel 8'h00, sprite 8'h81 prio=0 → 8'hC1 written.
- line_start during TILE → overrun pulse 1 cycle, linesel toggles, CLEAR restarts at idx 0.
- reset_n asserted mid-CLEAR → all outputs to reset values immediately (asynchronous), linesel=0.
